// File: rtl/dtree_pkg.sv
// Shared types and node-word layout helpers for the decision-tree sequencer.
// Word layout, MSB first: child_flags[2], one_pos[FEATURES], coeff0..coeffN-2, bias.
package dtree_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_BIAS,
        ST_FEAT,
        ST_WAIT_DIR,
        ST_DONE
    } state_t;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int nodes_of(input int max_depth);
        return (1 << max_depth) - 1;
    endfunction

    function automatic int word_width(input int features, input int coeff_w, input int bias_w);
        return 2 + features + (features - 1) * coeff_w + bias_w;
    endfunction

    function automatic int bias_lsb();
        return 0;
    endfunction

    function automatic int coeff_lsb(input int features, input int coeff_w, input int bias_w, input int k);
        return bias_w + (features - 2 - k) * coeff_w;
    endfunction

    function automatic int one_pos_lsb(input int features, input int coeff_w, input int bias_w);
        return bias_w + (features - 1) * coeff_w;
    endfunction

    function automatic int flags_lsb(input int features, input int coeff_w, input int bias_w);
        return one_pos_lsb(features, coeff_w, bias_w) + features;
    endfunction

endpackage

// File: rtl/dtree_sequencer_if.sv
// Request, config, datapath-step and result signals of the tree sequencer.
// master = host/datapath side, slave = sequencer.
interface dtree_sequencer_if #(
    parameter int FEATURES        = 3,
    parameter int COEFF_BIT_DEPTH = 4,
    parameter int BIAS_BIT_DEPTH  = 10,
    parameter int MAX_DEPTH       = 3,
    parameter int CHANNEL_COUNT   = 16
);
    import dtree_pkg::*;

    localparam int NODES = nodes_of(MAX_DEPTH);
    localparam int CW    = clog2_min1(CHANNEL_COUNT);
    localparam int AW    = clog2_min1(CHANNEL_COUNT * NODES);
    localparam int W     = word_width(FEATURES, COEFF_BIT_DEPTH, BIAS_BIT_DEPTH);
    localparam int LW    = clog2_min1(MAX_DEPTH + 1);

    logic                       in_valid;
    logic                       in_ready;
    logic [CW-1:0]              in_channel;
    logic                       cfg_we;
    logic                       cfg_ready;
    logic [AW-1:0]              cfg_addr;
    logic [W-1:0]               cfg_data;
    logic                       node_valid;
    logic                       load_bias;
    logic [BIAS_BIT_DEPTH-1:0]  bias;
    logic                       mult;
    logic                       add;
    logic                       is_one;
    logic                       is_zero;
    logic [COEFF_BIT_DEPTH-1:0] coeff;
    logic                       dir_valid;
    logic                       child_direction;
    logic                       out_valid;
    logic                       out_ready;
    logic [CW-1:0]              out_channel;
    logic [LW-1:0]              out_level;
    logic [MAX_DEPTH-1:0]       out_path;

    modport master (
        output in_valid, in_channel, cfg_we, cfg_addr, cfg_data,
               dir_valid, child_direction, out_ready,
        input  in_ready, cfg_ready, node_valid, load_bias, bias, mult, add,
               is_one, is_zero, coeff, out_valid, out_channel, out_level, out_path
    );

    modport slave (
        input  in_valid, in_channel, cfg_we, cfg_addr, cfg_data,
               dir_valid, child_direction, out_ready,
        output in_ready, cfg_ready, node_valid, load_bias, bias, mult, add,
               is_one, is_zero, coeff, out_valid, out_channel, out_level, out_path
    );

endinterface

// File: rtl/dtree_node_ram.sv
// 1R1W node-word RAM, no reset; read data registered (1-cycle latency).
// No backpressure: one write and one read may happen every cycle.
module dtree_node_ram #(
    parameter int WORDS  = 16,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dtree_sequencer.sv
// Walks one channel's heap-ordered tree per request, one FEATURES+3 cycle step per node minimum.
// Accepts requests/config only in IDLE; the result is held in DONE until out_ready.
module dtree_sequencer
    import dtree_pkg::*;
#(
    parameter int FEATURES        = 3,
    parameter int COEFF_BIT_DEPTH = 4,
    parameter int BIAS_BIT_DEPTH  = 10,
    parameter int MAX_DEPTH       = 3,
    parameter int CHANNEL_COUNT   = 16
) (
    input  logic             clk,
    input  logic             reset,
    dtree_sequencer_if.slave bus
);

    localparam int NODES    = nodes_of(MAX_DEPTH);
    localparam int W        = word_width(FEATURES, COEFF_BIT_DEPTH, BIAS_BIT_DEPTH);
    localparam int CW       = clog2_min1(CHANNEL_COUNT);
    localparam int AW       = clog2_min1(CHANNEL_COUNT * NODES);
    localparam int LW       = clog2_min1(MAX_DEPTH + 1);
    localparam int NW       = clog2_min1(NODES);
    localparam int FW       = clog2_min1(FEATURES);
    localparam int KW       = clog2_min1(FEATURES - 1);
    localparam int ONE_LSB  = one_pos_lsb(FEATURES, COEFF_BIT_DEPTH, BIAS_BIT_DEPTH);
    localparam int FLAG_LSB = flags_lsb(FEATURES, COEFF_BIT_DEPTH, BIAS_BIT_DEPTH);
    localparam int BIAS_LSB = bias_lsb();

    state_t                     state, state_nxt;
    logic [CW-1:0]              channel_q;
    logic [NW-1:0]              node_q;
    logic [LW-1:0]              depth_q;
    logic [MAX_DEPTH-1:0]       path_q;
    logic [FW-1:0]              feat_q;
    logic [KW-1:0]              k_q;
    logic                       out_valid_q;
    logic [CW-1:0]              out_channel_q;
    logic [LW-1:0]              out_level_q;
    logic [MAX_DEPTH-1:0]       out_path_q;

    logic [AW-1:0]              rd_addr;
    logic [W-1:0]               word;
    logic [1:0]                 flags;
    logic [FEATURES-1:0]        one_pos;
    logic [COEFF_BIT_DEPTH-1:0] coeffs [FEATURES-1];
    logic [COEFF_BIT_DEPTH-1:0] coeff_k;
    logic                       unity;
    logic                       last_feat;
    logic                       child_ok;
    logic [NW-1:0]              child_node;
    logic [MAX_DEPTH-1:0]       path_nxt;
    logic                       idle;

    logic                       node_valid_c, load_bias_c, mult_c, add_c, is_one_c, is_zero_c;
    logic [BIAS_BIT_DEPTH-1:0]  bias_c;
    logic [COEFF_BIT_DEPTH-1:0] coeff_c;

    assign idle    = (state == ST_IDLE);
    // Address stays fixed from FETCH to WAIT_DIR, so the RAM keeps re-reading the same word.
    assign rd_addr = AW'(channel_q) * AW'(NODES) + AW'(node_q);

    dtree_node_ram #(
        .WORDS  (CHANNEL_COUNT * NODES),
        .WIDTH  (W),
        .ADDR_W (AW)
    ) u_node_ram (
        .clk   (clk),
        .we    (bus.cfg_we & idle),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_data),
        .raddr (rd_addr),
        .rdata (word)
    );

    assign flags   = word[FLAG_LSB +: 2];
    assign one_pos = word[ONE_LSB +: FEATURES];

    for (genvar g = 0; g < FEATURES - 1; g++) begin : g_coeff
        assign coeffs[g] = word[coeff_lsb(FEATURES, COEFF_BIT_DEPTH, BIAS_BIT_DEPTH, g) +: COEFF_BIT_DEPTH];
    end

    assign coeff_k    = coeffs[k_q];
    assign unity      = one_pos[FW'(FEATURES - 1) - feat_q];
    assign last_feat  = (feat_q == FW'(FEATURES - 1));
    assign child_ok   = (bus.child_direction ? flags[0] : flags[1]) && (depth_q < LW'(MAX_DEPTH - 1));
    assign child_node = NW'({node_q, 1'b0}) + NW'(1) + NW'(bus.child_direction);
    assign path_nxt   = path_q | (MAX_DEPTH'(bus.child_direction) << depth_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (bus.in_valid) state_nxt = ST_FETCH;
            ST_FETCH:    state_nxt = ST_BIAS;
            ST_BIAS:     state_nxt = ST_FEAT;
            ST_FEAT:     if (last_feat) state_nxt = ST_WAIT_DIR;
            ST_WAIT_DIR: if (bus.dir_valid) state_nxt = child_ok ? ST_FETCH : ST_DONE;
            ST_DONE:     if (bus.out_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            channel_q     <= '0;
            node_q        <= '0;
            depth_q       <= '0;
            path_q        <= '0;
            feat_q        <= '0;
            k_q           <= '0;
            out_valid_q   <= 1'b0;
            out_channel_q <= '0;
            out_level_q   <= '0;
            out_path_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid) begin
                    channel_q <= bus.in_channel;
                    node_q    <= '0;
                    depth_q   <= '0;
                    path_q    <= '0;
                end
                ST_BIAS: begin
                    feat_q <= '0;
                    k_q    <= '0;
                end
                ST_FEAT: begin
                    feat_q <= feat_q + FW'(1);
                    // Saturate so a word with no unity bit never walks past the last coeff slot.
                    if (!unity && (k_q < KW'(FEATURES - 2))) begin
                        k_q <= k_q + KW'(1);
                    end
                end
                ST_WAIT_DIR: if (bus.dir_valid) begin
                    path_q <= path_nxt;
                    if (child_ok) begin
                        node_q  <= child_node;
                        depth_q <= depth_q + LW'(1);
                    end else begin
                        out_valid_q   <= 1'b1;
                        out_channel_q <= channel_q;
                        out_level_q   <= depth_q;
                        out_path_q    <= path_nxt;
                    end
                end
                ST_DONE: if (bus.out_ready) out_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        node_valid_c = 1'b0;
        load_bias_c  = 1'b0;
        bias_c       = '0;
        mult_c       = 1'b0;
        add_c        = 1'b0;
        is_one_c     = 1'b0;
        is_zero_c    = 1'b0;
        coeff_c      = '0;
        case (state)
            ST_BIAS: begin
                node_valid_c = 1'b1;
                load_bias_c  = 1'b1;
                bias_c       = word[BIAS_LSB +: BIAS_BIT_DEPTH];
            end
            ST_FEAT: begin
                node_valid_c = 1'b1;
                if (unity) begin
                    is_one_c = 1'b1;
                    add_c    = 1'b1;
                end else if (coeff_k == '0) begin
                    is_zero_c = 1'b1;
                end else begin
                    mult_c  = 1'b1;
                    add_c   = 1'b1;
                    coeff_c = coeff_k;
                end
            end
            default: ;
        endcase
    end

    assign bus.in_ready    = idle;
    assign bus.cfg_ready   = idle;
    assign bus.node_valid  = node_valid_c;
    assign bus.load_bias   = load_bias_c;
    assign bus.bias        = bias_c;
    assign bus.mult        = mult_c;
    assign bus.add         = add_c;
    assign bus.is_one      = is_one_c;
    assign bus.is_zero     = is_zero_c;
    assign bus.coeff       = coeff_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_channel = out_channel_q;
    assign bus.out_level   = out_level_q;
    assign bus.out_path    = out_path_q;

endmodule

// File: tb/tb_dtree_sequencer.sv
// Directed bench: configures small trees, walks them, scoreboards results and datapath traces.
module tb_dtree_sequencer;

    localparam int F  = 3;
    localparam int CB = 4;
    localparam int BB = 10;
    localparam int MD = 3;
    localparam int CC = 4;

    typedef struct {
        int         ch;
        int         lv;
        logic [2:0] path;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int          total = 0;
    int          bad = 0;
    exp_t        sb[$];
    logic [22:0] m_word [CC*7];
    bit          poke_cfg = 1'b0;
    logic [19:0] dp_obs;

    dtree_sequencer_if #(.FEATURES(F), .COEFF_BIT_DEPTH(CB), .BIAS_BIT_DEPTH(BB),
                         .MAX_DEPTH(MD), .CHANNEL_COUNT(CC)) bus ();

    dtree_sequencer #(.FEATURES(F), .COEFF_BIT_DEPTH(CB), .BIAS_BIT_DEPTH(BB),
                      .MAX_DEPTH(MD), .CHANNEL_COUNT(CC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign dp_obs = {bus.node_valid, bus.load_bias, bus.mult, bus.add, bus.is_one,
                     bus.is_zero, bus.coeff, bus.bias};

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [22:0] mk(input logic [1:0] fl, input logic [2:0] op,
                                      input logic [3:0] c0, input logic [3:0] c1, input logic [9:0] b);
        return {fl, op, c0, c1, b};
    endfunction

    task automatic cfg_write(input int ch, input int node, input logic [22:0] w);
        chk("cfg_ready_idle", 32'(bus.cfg_ready), 1);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 5'(ch * 7 + node);
        bus.cfg_data = w;
        step();
        bus.cfg_we = 1'b0;
        m_word[ch*7+node] = w;
    endtask

    // Entered in the FETCH cycle of a node; leaves one cycle after dir_valid is taken.
    task automatic serve_node(input int ch, input int node, input bit dir, input int dly);
        logic [22:0] w;
        logic [2:0]  op;
        logic [3:0]  c [2];
        logic [3:0]  ck;
        logic [5:0]  ef;
        int          k;
        w    = m_word[ch*7+node];
        op   = w[20:18];
        c[0] = w[17:14];
        c[1] = w[13:10];
        chk("fetch_dp", 32'(dp_obs), 0);
        step();
        chk("bias_flags", 32'(dp_obs[19:14]), 32'h30);
        chk("bias_value", 32'(bus.bias), 32'(w[9:0]));
        if (dly > 0) begin
            bus.dir_valid       = 1'b1;
            bus.child_direction = ~dir;
        end
        if (poke_cfg) begin
            chk("cfg_ready_busy", 32'(bus.cfg_ready), 0);
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = 5'(3 * 7);
            bus.cfg_data = 23'h7FFFFF;
        end
        step();
        k = 0;
        for (int f = 0; f < F; f++) begin
            ck = c[k];
            if (op[2-f]) begin
                ef = 6'b100110;
            end else if (ck == 4'd0) begin
                ef = 6'b100001;
                k  = (k < 1) ? k + 1 : k;
            end else begin
                ef = 6'b101100;
                k  = (k < 1) ? k + 1 : k;
            end
            chk($sformatf("feat%0d_flags_n%0d", f, node), 32'(dp_obs[19:14]), 32'(ef));
            if (ef[3]) chk($sformatf("feat%0d_coeff_n%0d", f, node), 32'(bus.coeff), 32'(ck));
            chk("in_ready_busy", 32'(bus.in_ready), 0);
            if (f == F - 1) begin
                bus.dir_valid = 1'b0;
                bus.cfg_we    = 1'b0;
            end
            step();
        end
        for (int d = 0; d < dly; d++) begin
            chk("wait_dp", 32'(dp_obs), 0);
            step();
        end
        chk("wait_dp_dir", 32'(dp_obs), 0);
        bus.dir_valid       = 1'b1;
        bus.child_direction = dir;
        step();
        bus.dir_valid = 1'b0;
    endtask

    task automatic traverse(input int ch, input logic [2:0] dirs, input int dly,
                            input int exp_lv, input logic [2:0] exp_path);
        int          node;
        int          depth;
        bit          more;
        logic [22:0] w;
        exp_t        e;
        node  = 0;
        depth = 0;
        more  = 1'b1;
        e.ch = ch; e.lv = exp_lv; e.path = exp_path;
        sb.push_back(e);
        chk("in_ready_req", 32'(bus.in_ready), 1);
        bus.in_valid   = 1'b1;
        bus.in_channel = 2'(ch);
        step();
        bus.in_valid = 1'b0;
        while (more) begin
            w = m_word[ch*7+node];
            serve_node(ch, node, dirs[depth], dly);
            if (depth < 2 && (dirs[depth] ? w[21] : w[22])) begin
                node  = 2 * node + 1 + int'(dirs[depth]);
                depth = depth + 1;
            end else begin
                more = 1'b0;
            end
        end
    endtask

    task automatic collect(input int hold, input bit poke_in);
        int   waited;
        exp_t e;
        waited = 0;
        while (bus.out_valid !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        chk("out_valid_rise", 32'(bus.out_valid), 1);
        chk("sb_outstanding", 32'(sb.size()), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (poke_in) begin
                bus.in_valid   = 1'b1;
                bus.in_channel = 2'd1;
            end
            for (int i = 0; i <= hold; i++) begin
                chk("out_channel", 32'(bus.out_channel), 32'(e.ch));
                chk("out_level", 32'(bus.out_level), 32'(e.lv));
                chk("out_path", 32'(bus.out_path), 32'(e.path));
                chk("out_valid_hold", 32'(bus.out_valid), 1);
                chk("in_ready_done", 32'(bus.in_ready), 0);
                if (i < hold) step();
            end
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("out_valid_fall", 32'(bus.out_valid), 0);
        chk("in_ready_back", 32'(bus.in_ready), 1);
        if (poke_in) begin
            for (int i = 0; i < 3; i++) begin
                step();
                chk("no_extra_walk", 32'(dp_obs), 0);
                chk("still_idle", 32'(bus.in_ready), 1);
            end
        end
    endtask

    initial begin
        bus.in_valid        = 1'b0;
        bus.in_channel      = '0;
        bus.cfg_we          = 1'b0;
        bus.cfg_addr        = '0;
        bus.cfg_data        = '0;
        bus.dir_valid       = 1'b0;
        bus.child_direction = 1'b0;
        bus.out_ready       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dp", 32'(dp_obs), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_level", 32'(bus.out_level), 0);
        chk("rst_out_path", 32'(bus.out_path), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk) reset = 1'b1;
        step();

        cfg_write(2, 0, mk(2'b11, 3'b100, 4'd5, 4'd0, 10'h12A));
        cfg_write(2, 1, mk(2'b00, 3'b001, 4'd0, 4'd0, 10'h021));
        cfg_write(2, 2, mk(2'b00, 3'b010, 4'd3, 4'd7, 10'h022));
        for (int n = 0; n < 7; n++) begin
            logic [2:0] op;
            op = (n == 6) ? 3'b000 : (n == 5) ? 3'b101 : 3'(3'b001 << (n % 3));
            cfg_write(1, n, mk(2'b11, op, 4'(n + 1), 4'((3 * n) & 15), 10'(32'h100 + n)));
        end
        cfg_write(3, 0, mk(2'b00, 3'b100, 4'd1, 4'd2, 10'h033));

        // Right to a leaf at level 1, then left at the leaf.
        traverse(2, 3'b001, 0, 1, 3'b001);
        collect(0, 1'b0);

        // Full-depth walk 0 -> 2 -> 6, including a word with no unity bit.
        traverse(1, 3'b111, 0, 2, 3'b111);
        collect(0, 1'b0);

        // Late dir_valid with stray dir_valid during FEAT, slow out_ready, ignored in_valid.
        traverse(2, 3'b001, 5, 1, 3'b001);
        collect(4, 1'b1);

        // Config writes attempted mid-walk must be dropped.
        poke_cfg = 1'b1;
        traverse(3, 3'b001, 0, 0, 3'b001);
        poke_cfg = 1'b0;
        collect(0, 1'b0);
        traverse(3, 3'b001, 0, 0, 3'b001);
        collect(0, 1'b0);
        cfg_write(3, 0, mk(2'b00, 3'b010, 4'd0, 4'd9, 10'h0AB));
        traverse(3, 3'b000, 0, 0, 3'b000);
        collect(0, 1'b0);

        // Asynchronous reset in the middle of node 1.
        bus.in_valid   = 1'b1;
        bus.in_channel = 2'd1;
        step();
        bus.in_valid = 1'b0;
        serve_node(1, 0, 1'b0, 0);
        chk("n1_fetch_dp", 32'(dp_obs), 0);
        step();
        chk("n1_bias", 32'(bus.bias), 32'h101);
        step();
        chk("n1_feat_active", 32'(bus.node_valid), 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_dp", 32'(dp_obs), 0);
        chk("arst_out_valid", 32'(bus.out_valid), 0);
        chk("arst_out_level", 32'(bus.out_level), 0);
        chk("arst_out_path", 32'(bus.out_path), 0);
        chk("arst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk) reset = 1'b1;
        step();
        traverse(1, 3'b111, 0, 2, 3'b111);
        collect(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
